// File: rtl/chip_access_seq.sv
// rtl/chip_access_seq.sv - host-access sequencer for the YM2203 pair and the SAA1099
//
// Turns single-cycle host access strobes into timed chip cycles on the internal
// data bus. One request may wait in a pending slot while a chip cycle runs; a
// newer request replaces it and pulses overflow. Every output is registered.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   wraddr_beg/wrdata_beg/rddata_beg  host strobes (read > data write > address write)
//   din, ym_sel, ym_stat, saa_ena     request attributes, sampled with the strobe
//   d_in                              internal data bus read value
//   d_out, d_oe                       internal data bus write value and drive enable
//   yma0, ymcs0_n, ymcs1_n, ymrd_n, ymwr_n   YM2203 address and strobes
//   saaa0, saacs_n, saawr_n           SAA1099 address and strobes
//   wr_port                           config-port write pulse (address write of 8'hFx)
//   rd_data, rd_valid                 read result and its one-cycle update pulse
//   busy, overflow                    chip cycle in progress, pending slot overwritten
module chip_access_seq #(
    parameter int YM_SETUP  = 1,
    parameter int YM_PULSE  = 14,
    parameter int YM_HOLD   = 1,
    parameter int SAA_CS2WR = 3,
    parameter int SAA_PULSE = 6,
    parameter int SAA_HOLD  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wraddr_beg,
    input  logic       wrdata_beg,
    input  logic       rddata_beg,
    input  logic [7:0] din,
    input  logic       ym_sel,
    input  logic       ym_stat,
    input  logic       saa_ena,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       yma0,
    output logic       ymcs0_n,
    output logic       ymcs1_n,
    output logic       ymrd_n,
    output logic       ymwr_n,
    output logic       saaa0,
    output logic       saacs_n,
    output logic       saawr_n,
    output logic       wr_port,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       overflow
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD} state_t;
    typedef enum logic [1:0] {RQ_ADDR, RQ_DATA, RQ_READ} rq_kind_t;

    typedef struct packed {
        rq_kind_t   kind;
        logic [7:0] data;
        logic       ym_sel;
        logic       ym_stat;
        logic       saa_ena;
    } req_t;

    // Counter reload values: each phase lasts N cycles, counting N-1 down to 0.
    localparam logic [4:0] YM_SETUP_LD  = 5'(YM_SETUP - 1);
    localparam logic [4:0] YM_PULSE_LD  = 5'(YM_PULSE - 1);
    localparam logic [4:0] YM_HOLD_LD   = 5'(YM_HOLD - 1);
    localparam logic [4:0] SAA_CS2WR_LD = 5'(SAA_CS2WR - 1);
    localparam logic [4:0] SAA_PULSE_LD = 5'(SAA_PULSE - 1);
    localparam logic [4:0] SAA_HOLD_LD  = 5'(SAA_HOLD - 1);

    state_t     state, state_d;
    logic [4:0] cnt, cnt_d;
    req_t       cur, cur_d;
    req_t       pend, pend_d;
    logic       pend_v, pend_v_d;

    req_t       new_req, start_req;
    logic       req_valid, cfg_hit, start, is_wr;

    logic [7:0] d_out_d, rd_data_d;
    logic       d_oe_d, yma0_d, ymcs0_n_d, ymcs1_n_d, ymrd_n_d, ymwr_n_d;
    logic       saaa0_d, saacs_n_d, saawr_n_d;
    logic       wr_port_d, rd_valid_d, busy_d, overflow_d;

    always_comb begin
        // Request decode. A config write only counts when the address write
        // wins arbitration; it never reaches the chip sequencer.
        new_req.kind    = rddata_beg ? RQ_READ : (wrdata_beg ? RQ_DATA : RQ_ADDR);
        new_req.data    = din;
        new_req.ym_sel  = ym_sel;
        new_req.ym_stat = ym_stat;
        new_req.saa_ena = saa_ena;
        cfg_hit   = wraddr_beg & ~rddata_beg & ~wrdata_beg & (din[7:4] == 4'hF);
        req_valid = (rddata_beg | wrdata_beg | wraddr_beg) & ~cfg_hit;

        state_d    = state;
        cnt_d      = cnt;
        cur_d      = cur;
        pend_d     = pend;
        pend_v_d   = pend_v;
        start      = 1'b0;
        start_req  = new_req;
        rd_data_d  = rd_data;
        rd_valid_d = 1'b0;
        overflow_d = 1'b0;
        wr_port_d  = cfg_hit;

        case (state)
            ST_IDLE: begin
                // The waiting request goes first; a strobe arriving in the same
                // cycle takes over the freshly emptied slot.
                if (pend_v) begin
                    start     = 1'b1;
                    start_req = pend;
                    pend_d    = new_req;
                    pend_v_d  = req_valid;
                end else if (req_valid) begin
                    start     = 1'b1;
                    start_req = new_req;
                end
            end
            ST_SETUP: begin
                if (cnt == 5'd0) begin
                    state_d = ST_PULSE;
                    cnt_d   = cur.saa_ena ? SAA_PULSE_LD : YM_PULSE_LD;
                end else begin
                    cnt_d = cnt - 5'd1;
                end
            end
            ST_PULSE: begin
                if (cnt == 5'd0) begin
                    state_d = ST_HOLD;
                    cnt_d   = cur.saa_ena ? SAA_HOLD_LD : YM_HOLD_LD;
                    // Last cycle with ymrd_n low: the chip is driving d_in.
                    if (!cur.saa_ena && cur.kind == RQ_READ) begin
                        rd_data_d  = d_in;
                        rd_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt - 5'd1;
                end
            end
            ST_HOLD: begin
                if (cnt == 5'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt - 5'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state != ST_IDLE && req_valid) begin
            overflow_d = pend_v;
            pend_d     = new_req;
            pend_v_d   = 1'b1;
        end

        if (start) begin
            if (start_req.saa_ena && start_req.kind == RQ_READ) begin
                // The SAA1099 cannot be read: answer at once with all ones.
                rd_data_d  = 8'hFF;
                rd_valid_d = 1'b1;
            end else begin
                state_d = ST_SETUP;
                cnt_d   = start_req.saa_ena ? SAA_CS2WR_LD : YM_SETUP_LD;
                cur_d   = start_req;
            end
        end

        // Output image of the state being entered, so pins change together
        // with the state register.
        is_wr     = (cur_d.kind != RQ_READ);
        d_out_d   = d_out;
        d_oe_d    = 1'b0;
        yma0_d    = yma0;
        saaa0_d   = saaa0;
        ymcs0_n_d = 1'b1;
        ymcs1_n_d = 1'b1;
        ymrd_n_d  = 1'b1;
        ymwr_n_d  = 1'b1;
        saacs_n_d = 1'b1;
        saawr_n_d = 1'b1;
        if (state_d != ST_IDLE) begin
            if (cur_d.saa_ena) begin
                saacs_n_d = 1'b0;
                saawr_n_d = (state_d != ST_PULSE);
                saaa0_d   = (cur_d.kind == RQ_ADDR);
                d_out_d   = cur_d.data;
                d_oe_d    = 1'b1;
            end else begin
                case (cur_d.kind)
                    RQ_ADDR: yma0_d = 1'b0;
                    RQ_DATA: yma0_d = 1'b1;
                    default: yma0_d = ~cur_d.ym_stat;
                endcase
                d_oe_d = is_wr;
                if (is_wr) begin
                    d_out_d = cur_d.data;
                end
                if (state_d == ST_PULSE) begin
                    ymcs0_n_d = cur_d.ym_sel;
                    ymcs1_n_d = ~cur_d.ym_sel;
                    ymwr_n_d  = ~is_wr;
                    ymrd_n_d  = is_wr;
                end
            end
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 5'd0;
            cur      <= '0;
            pend     <= '0;
            pend_v   <= 1'b0;
            d_out    <= 8'h00;
            d_oe     <= 1'b0;
            yma0     <= 1'b0;
            ymcs0_n  <= 1'b1;
            ymcs1_n  <= 1'b1;
            ymrd_n   <= 1'b1;
            ymwr_n   <= 1'b1;
            saaa0    <= 1'b0;
            saacs_n  <= 1'b1;
            saawr_n  <= 1'b1;
            wr_port  <= 1'b0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            cur      <= cur_d;
            pend     <= pend_d;
            pend_v   <= pend_v_d;
            d_out    <= d_out_d;
            d_oe     <= d_oe_d;
            yma0     <= yma0_d;
            ymcs0_n  <= ymcs0_n_d;
            ymcs1_n  <= ymcs1_n_d;
            ymrd_n   <= ymrd_n_d;
            ymwr_n   <= ymwr_n_d;
            saaa0    <= saaa0_d;
            saacs_n  <= saacs_n_d;
            saawr_n  <= saawr_n_d;
            wr_port  <= wr_port_d;
            rd_data  <= rd_data_d;
            rd_valid <= rd_valid_d;
            busy     <= busy_d;
            overflow <= overflow_d;
        end
    end

endmodule

// File: tb/tb_chip_access_seq.sv
// tb/tb_chip_access_seq.sv - scoreboard bench for chip_access_seq
module tb_chip_access_seq;

    localparam int YS = 1, YP = 14, YH = 1;
    localparam int SC = 3, SP = 6, SH = 1;
    localparam int YM_LEN  = YS + YP + YH;
    localparam int SAA_LEN = SC + SP + SH;
    localparam int MAXC    = 8192;

    logic       clk = 1'b0, rst = 1'b1;
    logic       wraddr_beg = 1'b0, wrdata_beg = 1'b0, rddata_beg = 1'b0;
    logic [7:0] din = 8'h00, d_in = 8'h00;
    logic       ym_sel = 1'b0, ym_stat = 1'b0, saa_ena = 1'b0;
    logic [7:0] d_out, rd_data;
    logic       d_oe, yma0, ymcs0_n, ymcs1_n, ymrd_n, ymwr_n;
    logic       saaa0, saacs_n, saawr_n, wr_port, rd_valid, busy, overflow;

    chip_access_seq dut (
        .clk(clk), .rst(rst),
        .wraddr_beg(wraddr_beg), .wrdata_beg(wrdata_beg), .rddata_beg(rddata_beg),
        .din(din), .ym_sel(ym_sel), .ym_stat(ym_stat), .saa_ena(saa_ena),
        .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
        .yma0(yma0), .ymcs0_n(ymcs0_n), .ymcs1_n(ymcs1_n), .ymrd_n(ymrd_n), .ymwr_n(ymwr_n),
        .saaa0(saaa0), .saacs_n(saacs_n), .saawr_n(saawr_n),
        .wr_port(wr_port), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int kind; logic [7:0] data; bit sel; bit stat; bit saa; } mreq_t;
    typedef struct { bit saa; bit cs; bit rd; bit a0; logic [7:0] data; int start; } bus_t;
    typedef struct { int vcyc; int hcyc; logic [7:0] val; } rd_t;

    bus_t       exp_bus[$];
    rd_t        exp_rd[$];
    bit         exp_busy[MAXC];
    bit         exp_wrp[MAXC];
    bit         exp_ovf[MAXC];
    logic [7:0] hist[MAXC];

    int    n_chk = 0, n_fail = 0;
    bit    mon_off = 1'b1;
    int    free_at = 0;
    bit    pend_v = 1'b0;
    mreq_t pend;

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a chip is free again at free_at; one waiting slot.
    task automatic model_start(mreq_t r, int c);
        int   s;
        bus_t b;
        rd_t  q;
        s = c + 1;
        if (r.saa && r.kind == 2) begin
            q.vcyc = c + 1; q.hcyc = -1; q.val = 8'hFF;
            exp_rd.push_back(q);
            free_at = c + 1;
        end else begin
            b.saa   = r.saa;
            b.cs    = r.saa ? 1'b0 : r.sel;
            b.rd    = (r.kind == 2);
            b.a0    = r.saa ? (r.kind == 0) : (r.kind == 0 ? 1'b0 : (r.kind == 1 ? 1'b1 : !r.stat));
            b.data  = (r.kind == 2) ? 8'h00 : r.data;
            b.start = s;
            exp_bus.push_back(b);
            for (int i = 0; i < (r.saa ? SAA_LEN : YM_LEN); i++) exp_busy[s + i] = 1'b1;
            if (!r.saa && r.kind == 2) begin
                q.vcyc = s + YS + YP; q.hcyc = s + YS + YP - 1; q.val = 8'h00;
                exp_rd.push_back(q);
            end
            free_at = s + (r.saa ? SAA_LEN : YM_LEN);
        end
    endtask

    task automatic model_step(int c, bit rd, bit wr, bit ad, logic [7:0] dn, bit sel, bit stat, bit saa);
        mreq_t r;
        bit    have;
        if (pend_v && c >= free_at) begin
            model_start(pend, c);
            pend_v = 1'b0;
        end
        have   = rd | wr | ad;
        r.kind = rd ? 2 : (wr ? 1 : 0);
        r.data = dn; r.sel = sel; r.stat = stat; r.saa = saa;
        if (ad && !rd && !wr && dn[7:4] == 4'hF) begin
            exp_wrp[c + 1] = 1'b1;
            have = 1'b0;
        end
        if (have) begin
            if (!pend_v && c >= free_at) model_start(r, c);
            else begin
                if (pend_v) exp_ovf[c + 1] = 1'b1;
                pend   = r;
                pend_v = 1'b1;
            end
        end
    endtask

    task automatic drive(bit rd, bit wr, bit ad, logic [7:0] dn, bit sel, bit stat, bit saa);
        @(posedge clk); #1;
        rddata_beg = rd; wrdata_beg = wr; wraddr_beg = ad;
        din = dn; ym_sel = sel; ym_stat = stat; saa_ena = saa;
        d_in = 8'($urandom);
        hist[cyc] = d_in;
        model_step(cyc, rd, wr, ad, dn, sel, stat, saa);
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_ymcs0_n"}, ymcs0_n, 1);
        chk({tag, "_ymcs1_n"}, ymcs1_n, 1);
        chk({tag, "_ymrd_n"}, ymrd_n, 1);
        chk({tag, "_ymwr_n"}, ymwr_n, 1);
        chk({tag, "_saacs_n"}, saacs_n, 1);
        chk({tag, "_saawr_n"}, saawr_n, 1);
        chk({tag, "_d_oe"}, d_oe, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_yma0"}, yma0, 0);
        chk({tag, "_saaa0"}, saaa0, 0);
        chk({tag, "_wr_port"}, wr_port, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_d_out"}, d_out, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
    endtask

    // Monitor: rebuilds chip cycles from the pins and checks them against the
    // scoreboard queues when each cycle ends.
    bit   y_act = 1'b0, s_act = 1'b0, y_oe_and, y_oe_or, y_bad, s_oe, s_bad, exp_v;
    int   y_st, s_st, w_st, w_en;
    bus_t yo, so, e;
    rd_t  rq;
    logic [7:0] ev;

    always @(negedge clk) begin
        if (mon_off) begin
            y_act = 1'b0; s_act = 1'b0; w_st = -1; w_en = -1;
        end else begin
            chk("busy", busy, exp_busy[cyc]);
            chk("wr_port", wr_port, exp_wrp[cyc]);
            chk("overflow", overflow, exp_ovf[cyc]);

            exp_v = (exp_rd.size() > 0) && (exp_rd[0].vcyc == cyc);
            chk("rd_valid", rd_valid, exp_v);
            if (exp_v) begin
                rq = exp_rd.pop_front();
                ev = (rq.hcyc < 0) ? rq.val : hist[rq.hcyc];
                chk("rd_data", rd_data, ev);
            end

            if (!ymcs0_n || !ymcs1_n) begin
                if (!y_act) begin
                    y_act = 1'b1; y_st = cyc;
                    yo.saa = 1'b0; yo.cs = !ymcs1_n; yo.rd = !ymrd_n; yo.a0 = yma0;
                    yo.data = yo.rd ? 8'h00 : d_out;
                    y_oe_and = d_oe; y_oe_or = d_oe; y_bad = 1'b0;
                end
                y_oe_and &= d_oe;
                y_oe_or  |= d_oe;
                if ((!ymcs0_n && !ymcs1_n) || (ymrd_n == ymwr_n) || (!ymrd_n != yo.rd) || (yma0 != yo.a0))
                    y_bad = 1'b1;
            end else begin
                chk("ym_rdwr_idle", {ymrd_n, ymwr_n}, 3);
                if (y_act) begin
                    y_act = 1'b0;
                    if (exp_bus.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL ym_cycle: got unexpected cycle, expected none (cycle %0d)", cyc);
                    end else begin
                        e = exp_bus.pop_front();
                        chk("bus_is_ym", e.saa, 0);
                        chk("ym_cs_rd_a0", {yo.cs, yo.rd, yo.a0}, {e.cs, e.rd, e.a0});
                        chk("ym_d_out", yo.data, e.data);
                        chk("ym_strobe_start", y_st, e.start + YS);
                        chk("ym_strobe_len", cyc - y_st, YP);
                        chk("ym_d_oe", e.rd ? y_oe_or : y_oe_and, e.rd ? 0 : 1);
                        chk("ym_strobe_shape", y_bad, 0);
                    end
                end
            end

            if (!saacs_n) begin
                if (!s_act) begin
                    s_act = 1'b1; s_st = cyc; w_st = -1; w_en = -1;
                    so.a0 = saaa0; so.data = d_out; s_oe = 1'b1; s_bad = 1'b0;
                end
                s_oe &= d_oe;
                if (!saawr_n && w_st < 0) w_st = cyc;
                if (saawr_n && w_st >= 0 && w_en < 0) w_en = cyc;
                if (!saawr_n && w_en >= 0) s_bad = 1'b1;
            end else begin
                chk("saa_wr_idle", saawr_n, 1);
                if (s_act) begin
                    s_act = 1'b0;
                    if (exp_bus.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL saa_cycle: got unexpected cycle, expected none (cycle %0d)", cyc);
                    end else begin
                        e = exp_bus.pop_front();
                        chk("bus_is_saa", e.saa, 1);
                        chk("saa_a0", so.a0, e.a0);
                        chk("saa_d_out", so.data, e.data);
                        chk("saa_cs_start", s_st, e.start);
                        chk("saa_cs_len", cyc - s_st, SAA_LEN);
                        chk("saa_wr_start", w_st, e.start + SC);
                        chk("saa_wr_len", w_en - w_st, SP);
                        chk("saa_d_oe", s_oe, 1);
                        chk("saa_wr_shape", s_bad, 0);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] dn;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        mon_off = 1'b0;
        free_at = cyc;

        drive(1'b0, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0);           // YM address write
        idle(25);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);           // YM #1 data read
        idle(25);
        drive(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);           // SAA data write
        idle(20);
        drive(1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0);           // queued behind
        idle(4);
        drive(1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0);
        idle(40);
        drive(1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);           // overflow
        idle(4);
        drive(1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        idle(2);
        drive(1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0);
        idle(40);
        drive(1'b0, 1'b1, 1'b0, 8'h66, 1'b1, 1'b0, 1'b0);           // config while busy
        idle(3);
        drive(1'b0, 1'b0, 1'b1, 8'hF2, 1'b0, 1'b0, 1'b0);
        idle(25);
        drive(1'b1, 1'b0, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0);           // read beats address write
        idle(25);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);           // SAA read
        idle(5);

        repeat (3000) begin
            dn = 8'($urandom);
            if ($urandom_range(3) == 0) dn[7:4] = 4'hF;
            drive(1'($urandom_range(39) == 0), 1'($urandom_range(24) == 0),
                  1'($urandom_range(19) == 0), dn, 1'($urandom), 1'($urandom),
                  1'($urandom_range(2) == 0));
        end
        idle(40);

        // Reset in the middle of a PULSE with a request waiting.
        drive(1'b0, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 1'b0);
        idle(2);
        drive(1'b0, 1'b1, 1'b0, 8'hB2, 1'b1, 1'b0, 1'b0);
        idle(5);
        @(posedge clk); #1;
        mon_off = 1'b1;
        rst = 1'b1;
        rddata_beg = 1'b0; wrdata_beg = 1'b0; wraddr_beg = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        exp_bus.delete();
        exp_rd.delete();
        pend_v = 1'b0;
        free_at = cyc;
        for (int i = cyc; i < MAXC; i++) begin
            exp_busy[i] = 1'b0; exp_wrp[i] = 1'b0; exp_ovf[i] = 1'b0;
        end
        mon_off = 1'b0;
        idle(40);
        drive(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        idle(25);

        chk("bus_queue_empty", exp_bus.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
